// File: rtl/xmpl_dsp_pkg.sv
// Shared constants and types for the xmpl DSP core.
// Latency: n/a (package only).
// Backpressure: n/a.
package xmpl_dsp_pkg;

    // Symmetric 7-tap droop-compensation FIR. The taps are C0 C1 C2 C3 C2 C1 C0,
    // and they sum to 1024, which gives unity DC gain after a 10-bit shift.
    localparam int COEF_W = 16;
    localparam logic signed [COEF_W-1:0] C0 = -16'sd16;
    localparam logic signed [COEF_W-1:0] C1 = 16'sd112;
    localparam logic signed [COEF_W-1:0] C2 = -16'sd480;
    localparam logic signed [COEF_W-1:0] C3 = 16'sd1792;

    localparam int COMP_NORM_SHIFT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        RND  = 2'd2,
        OUT  = 2'd3
    } comp_state_e;

endpackage

// File: rtl/xmpl_round_sat.sv
// Arithmetic right shift with round-half-up, then signed saturation to OUT_W bits.
// Latency: combinational (0 cycles).
// Backpressure: none (pure function of val_i).
// Ports: val_i  - signed IN_W input value
//        val_o  - rounded, shifted, clamped signed OUT_W result
//        clip_o - high when the rounded value lay outside the OUT_W range
// SHIFT must be at least 1, and IN_W+1 must exceed OUT_W.
module xmpl_round_sat #(
    parameter int IN_W  = 52,
    parameter int OUT_W = 24,
    parameter int SHIFT = 18
) (
    input  logic signed [IN_W-1:0]  val_i,
    output logic signed [OUT_W-1:0] val_o,
    output logic                    clip_o
);

    // One guard bit, so that adding the rounding constant cannot wrap.
    localparam int EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) <<< (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] MAXV = (EXT_W'(1) <<< (OUT_W - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] MINV = -(EXT_W'(1) <<< (OUT_W - 1));

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shr;

    always_comb begin
        ext    = $signed({val_i[IN_W-1], val_i});
        sum    = ext + HALF;
        shr    = sum >>> SHIFT;
        clip_o = 1'b0;
        val_o  = shr[OUT_W-1:0];
        if (shr > MAXV) begin
            val_o  = MAXV[OUT_W-1:0];
            clip_o = 1'b1;
        end else if (shr < MINV) begin
            val_o  = MINV[OUT_W-1:0];
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/xmpl_cic_comp.sv
// CIC droop compensation: 7-tap symmetric FIR on one shared multiplier, rounded and saturated.
// Latency: input handshake at T0, four MAC cycles, RND at T5, comp_valid_o high after T5.
// Backpressure: one sample in flight; cic_ready_o is high only in IDLE, and OUT holds until comp_ready_i.
// Ports: clk_i/reset_n_i (async active-low), cic_* input handshake, comp_* output handshake,
//        sat_clr_i clears the sticky clip flag sat_flag_o (a simultaneous set wins).
module xmpl_cic_comp #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 24,
    parameter int GAIN_SHIFT = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [IN_W-1:0]  cic_data_i,
    input  logic             cic_valid_i,
    output logic             cic_ready_o,
    output logic [OUT_W-1:0] comp_data_o,
    output logic             comp_valid_o,
    input  logic             comp_ready_i,
    input  logic             sat_clr_i,
    output logic             sat_flag_o
);
    import xmpl_dsp_pkg::*;

    localparam int PROD_W = IN_W + 17;
    localparam int ACC_W  = IN_W + 20;
    localparam int SHIFT  = COMP_NORM_SHIFT + GAIN_SHIFT;

    comp_state_e state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0]        out_q, out_d;
    logic                    sat_q, sat_d;
    logic                    shift_en;

    // x_q[0] holds the newest sample.
    logic signed [IN_W-1:0]  x_q [7];

    logic signed [IN_W-1:0]   tap_a, tap_b;
    logic signed [COEF_W-1:0] coef;
    logic signed [IN_W:0]     pre;
    logic signed [PROD_W-1:0] prod;

    logic signed [OUT_W-1:0]  rnd_val;
    logic                     rnd_clip;

    // Symmetric pairs share one pre-add, so four products cover seven taps.
    always_comb begin
        tap_a = x_q[0];
        tap_b = x_q[6];
        coef  = C0;
        case (idx_q)
            2'd1: begin
                tap_a = x_q[1];
                tap_b = x_q[5];
                coef  = C1;
            end
            2'd2: begin
                tap_a = x_q[2];
                tap_b = x_q[4];
                coef  = C2;
            end
            2'd3: begin
                tap_a = x_q[3];
                tap_b = '0;
                coef  = C3;
            end
            default: ;
        endcase
        pre  = $signed({tap_a[IN_W-1], tap_a}) + $signed({tap_b[IN_W-1], tap_b});
        prod = PROD_W'(pre) * PROD_W'(coef);
    end

    xmpl_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .val_i  (acc_q),
        .val_o  (rnd_val),
        .clip_o (rnd_clip)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        out_d    = out_q;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (cic_valid_i) begin
                    shift_en = 1'b1;
                    state_d  = MAC;
                    idx_d    = 2'd0;
                    acc_d    = '0;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = RND;
                end
            end
            RND: begin
                out_d   = rnd_val;
                state_d = OUT;
            end
            OUT: begin
                if (comp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ordering makes a clip in the RND cycle win over a same-cycle clear.
        sat_d = sat_q;
        if (sat_clr_i) begin
            sat_d = 1'b0;
        end
        if ((state_q == RND) && rnd_clip) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 7; i++) begin
                x_q[i] <= '0;
            end
        end else if (shift_en) begin
            x_q[0] <= cic_data_i;
            for (int i = 1; i < 7; i++) begin
                x_q[i] <= x_q[i-1];
            end
        end
    end

    assign cic_ready_o  = (state_q == IDLE);
    assign comp_valid_o = (state_q == OUT);
    assign comp_data_o  = out_q;
    assign sat_flag_o   = sat_q;

endmodule

// File: tb/tb_xmpl_cic_comp.sv
// Directed bench for xmpl_cic_comp: impulse, rounding, DC, clipping, backpressure, reset abort.
// Latency: n/a.
// Backpressure: driven explicitly through comp_ready_i.
module tb_xmpl_cic_comp;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [31:0] cic_data_i;
    logic        cic_valid_i;
    logic        cic_ready_o;
    logic [23:0] comp_data_o;
    logic        comp_valid_o;
    logic        comp_ready_i;
    logic        sat_clr_i;
    logic        sat_flag_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    xmpl_cic_comp #(
        .IN_W       (32),
        .OUT_W      (24),
        .GAIN_SHIFT (8)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .cic_data_i   (cic_data_i),
        .cic_valid_i  (cic_valid_i),
        .cic_ready_o  (cic_ready_o),
        .comp_data_o  (comp_data_o),
        .comp_valid_o (comp_valid_o),
        .comp_ready_i (comp_ready_i),
        .sat_clr_i    (sat_clr_i),
        .sat_flag_o   (sat_flag_o)
    );

    function automatic logic signed [31:0] sx(input logic [23:0] d);
        return {{8{d[23]}}, d};
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one sample and complete the input handshake.
    task automatic send(input logic [31:0] v);
        int n = 0;
        while (!cic_ready_o && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!cic_ready_o) chk("send_timeout", 0, 1);
        cic_data_i  = v;
        cic_valid_i = 1'b1;
        @(posedge clk_i); #1;
        cic_valid_i = 1'b0;
        cic_data_i  = '0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!comp_valid_o && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!comp_valid_o) chk("valid_timeout", 0, 1);
    endtask

    task automatic accept();
        @(posedge clk_i); #1;
    endtask

    task automatic xfer(input string tag, input logic [31:0] v, input logic signed [31:0] exp);
        send(v);
        wait_valid();
        chk(tag, sx(comp_data_o), exp);
        accept();
    endtask

    task automatic pass(input logic [31:0] v);
        send(v);
        wait_valid();
        accept();
    endtask

    logic signed [31:0] imp_exp [8] = '{-16, 112, -480, 1792, -480, 112, -16, 0};
    logic signed [31:0] rnd_exp [7] = '{0, 4, -15, 56, -15, 4, 0};
    logic signed [31:0] dc_exp  [8] = '{-16, 96, -384, 1408, 928, 1040, 1024, 1024};

    initial begin
        logic ok;
        logic seen;
        reset_n_i    = 1'b0;
        cic_data_i   = '0;
        cic_valid_i  = 1'b0;
        comp_ready_i = 1'b1;
        sat_clr_i    = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cic_ready", cic_ready_o, 1);
        chk("rst_comp_valid", comp_valid_o, 0);
        chk("rst_comp_data", sx(comp_data_o), 0);
        chk("rst_sat_flag", sat_flag_o, 0);
        reset_n_i = 1'b1;
        accept();

        // Impulse of 2^18 reproduces the coefficients exactly.
        for (int i = 0; i < 8; i++)
            xfer($sformatf("impulse%0d", i), (i == 0) ? 32'h0004_0000 : 32'h0, imp_exp[i]);
        chk("impulse_sat", sat_flag_o, 0);

        // Impulse of 2^13 lands on half-LSB boundaries: -0.5 -> 0, 3.5 -> 4.
        for (int i = 0; i < 7; i++)
            xfer($sformatf("round%0d", i), (i == 0) ? 32'h0000_2000 : 32'h0, rnd_exp[i]);

        // DC step ramps through partial coefficient sums to unity gain.
        for (int i = 0; i < 8; i++)
            xfer($sformatf("dc%0d", i), 32'h0004_0000, dc_exp[i]);
        chk("dc_sat", sat_flag_o, 0);

        // Positive full scale: the clip on the 7th sample coincides with a held clear; the set wins.
        for (int i = 0; i < 6; i++) pass(32'h7FFF_FFFF);
        sat_clr_i = 1'b1;
        send(32'h7FFF_FFFF);
        wait_valid();
        sat_clr_i = 1'b0;
        chk("pos_clip_data", sx(comp_data_o), 8388607);
        chk("pos_set_wins", sat_flag_o, 1);
        accept();
        sat_clr_i = 1'b1;
        accept();
        sat_clr_i = 1'b0;
        chk("pos_clr", sat_flag_o, 0);
        xfer("pos_clip_again", 32'h7FFF_FFFF, 8388607);
        chk("pos_flag_reset", sat_flag_o, 1);

        // Negative full scale settles exactly at the minimum without clipping.
        for (int i = 0; i < 6; i++) pass(32'h8000_0000);
        xfer("neg_settle", 32'h8000_0000, -8388608);
        sat_clr_i = 1'b1;
        accept();
        sat_clr_i = 1'b0;
        chk("neg_clr", sat_flag_o, 0);
        xfer("neg_fs0", 32'h8000_0000, -8388608);
        xfer("neg_fs1", 32'h8000_0000, -8388608);
        chk("neg_sat", sat_flag_o, 0);

        // Backpressure: the output is held for 20 cycles, then exactly one handshake.
        comp_ready_i = 1'b0;
        send(32'h8000_0000);
        wait_valid();
        chk("bp_data", sx(comp_data_o), -8388608);
        ok = 1'b1;
        repeat (20) begin
            @(posedge clk_i); #1;
            if (!comp_valid_o || comp_data_o !== 24'h80_0000 || cic_ready_o) ok = 1'b0;
        end
        chk("bp_stable", ok, 1);
        comp_ready_i = 1'b1;
        accept();
        chk("bp_valid_drop", comp_valid_o, 0);
        chk("bp_ready_back", cic_ready_o, 1);

        // Reset in the idx-2 MAC cycle aborts the sample and clears the delay line.
        send(32'h0004_0000);
        accept();
        accept();
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_ready", cic_ready_o, 1);
        chk("mid_rst_valid", comp_valid_o, 0);
        chk("mid_rst_data", sx(comp_data_o), 0);
        chk("mid_rst_sat", sat_flag_o, 0);
        accept();
        reset_n_i = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk_i); #1;
            if (comp_valid_o) seen = 1'b1;
        end
        chk("mid_rst_no_output", seen, 0);
        for (int i = 0; i < 8; i++)
            xfer($sformatf("post_rst_impulse%0d", i), (i == 0) ? 32'h0004_0000 : 32'h0, imp_exp[i]);
        chk("post_rst_sat", sat_flag_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
